// File: rtl/team_06_spi_pkg.sv
// Shared types and helpers for the team_06 SPI stream transmitter.
//   state_t   : controller states
//   MSB_FIRST : serialisation order of each word
//   cnt_w()   : width of a counter that must hold values 0..n-1
package team_06_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      WAIT,
      HOLD,
      GAP
   } state_t;

   localparam bit MSB_FIRST = 1'b1;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/team_06_spi_sclk_gen.sv
// SCLK generator: half-period counter plus the SCLK flop.
//   clk, rst   : system clock, async active-high reset
//   en         : counter runs while high, holds otherwise
//   restart    : zero the counter and park sclk at CPOL
//   tog_en     : allow sclk to toggle at terminal count
//   sclk       : registered SPI clock
//   tc         : terminal count of the current half-period (en qualified)
//   lead_strb  : cycle in which sclk leaves CPOL (takes effect next edge)
//   trail_strb : cycle in which sclk returns to CPOL
module team_06_spi_sclk_gen
   import team_06_spi_pkg::*;
#(
   parameter int   CLK_DIV = 24,
   parameter logic CPOL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   input  logic tog_en,
   output logic sclk,
   output logic tc,
   output logic lead_strb,
   output logic trail_strb
);

   localparam int            CW       = cnt_w(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          tog;

   assign tc         = en && (cnt == CNT_LAST);
   assign tog        = tc && tog_en;
   assign lead_strb  = tog && (sclk == CPOL);
   assign trail_strb = tog && (sclk != CPOL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         sclk <= CPOL;
      end else if (restart) begin
         cnt  <= '0;
         sclk <= CPOL;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + 1'b1;
         if (tog) sclk <= ~sclk;
      end
   end

endmodule

// File: rtl/team_06_spi_stream_tx.sv
// SPI master transmitter streaming DATA_W-bit words (MSB first, CPHA=0)
// from a valid/ready source, WORDS_PER_FRAME words per cs_n assertion.
//   clk, rst          : system clock, async active-high reset
//   in_data/in_valid  : upstream word and qualifier
//   in_ready          : word accepted on in_valid && in_ready
//   sclk, cs_n, mosi  : SPI pins to the ESP
//   busy              : frame in progress (SETUP..HOLD)
//   frame_done        : one-cycle pulse as cs_n deasserts
// Build macro TEAM_06_SPI_TX_CS_GAP_EN adds a 2*CLK_DIV deselect (GAP)
// state after each frame; undefined, HOLD returns straight to IDLE.
//
// state | meaning
// IDLE  | cs_n high, ready for the first word of a frame
// SETUP | cs_n low, MSB on mosi, one half-period before first leading edge
// SHIFT | sclk toggling; shift on trailing edges
// WAIT  | between words of a frame, sclk parked, ready for next word
// HOLD  | cs_n held low one half-period after the last trailing edge
// GAP   | cs_n high, not ready, minimum deselect time (macro builds only)
module team_06_spi_stream_tx
   import team_06_spi_pkg::*;
#(
   parameter int   DATA_W          = 8,
   parameter int   CLK_DIV         = 24,
   parameter int   WORDS_PER_FRAME = 1,
   parameter logic CPOL            = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              sclk,
   output logic              cs_n,
   output logic              mosi,
   output logic              busy,
   output logic              frame_done
);

   generate
      if (DATA_W < 2 || CLK_DIV < 2 || WORDS_PER_FRAME < 1) begin : g_bad_params
         $error("team_06_spi_stream_tx: illegal DATA_W/CLK_DIV/WORDS_PER_FRAME");
      end
   endgenerate

   localparam int            BW        = cnt_w(DATA_W + 1);
   localparam int            WW        = cnt_w(WORDS_PER_FRAME + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
   localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_FRAME - 1);

   state_t            state, state_nx;
   logic [DATA_W-1:0] sreg;
   logic [BW-1:0]     bit_cnt;
   logic [WW-1:0]     word_cnt;
   logic              accept, last_bit, last_word;
   logic              sg_en, sg_tog, sg_tc, lead_strb, trail_strb;
   logic              cs_n_nx, in_ready_nx, frame_done_nx;

   assign accept    = in_valid && in_ready;
   assign last_bit  = (bit_cnt == LAST_BIT);
   assign last_word = (word_cnt == LAST_WORD);
   assign sg_en     = (state == SETUP) || (state == SHIFT) || (state == HOLD) || (state == GAP);
   assign sg_tog    = (state == SETUP) || (state == SHIFT);
   assign mosi      = MSB_FIRST ? sreg[DATA_W-1] : sreg[0];

`ifdef TEAM_06_SPI_TX_CS_GAP_EN
   // bit_cnt is idle outside SHIFT, so it counts the two GAP half-periods.
   logic gap_done;
   assign gap_done = sg_tc && (bit_cnt == BW'(1));
`endif

   team_06_spi_sclk_gen #(
      .CLK_DIV (CLK_DIV),
      .CPOL    (CPOL)
   ) u_sclk_gen (
      .clk        (clk),
      .rst        (rst),
      .en         (sg_en),
      .restart    (accept),
      .tog_en     (sg_tog),
      .sclk       (sclk),
      .tc         (sg_tc),
      .lead_strb  (lead_strb),
      .trail_strb (trail_strb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (accept) state_nx = SETUP;
         SETUP: if (lead_strb) state_nx = SHIFT;
         SHIFT: if (trail_strb && last_bit) state_nx = last_word ? HOLD : WAIT;
         WAIT:  if (accept) state_nx = SHIFT;
`ifdef TEAM_06_SPI_TX_CS_GAP_EN
         HOLD:  if (sg_tc) state_nx = GAP;
         GAP:   if (gap_done) state_nx = IDLE;
`else
         HOLD:  if (sg_tc) state_nx = IDLE;
         GAP:   state_nx = IDLE;
`endif
         default: state_nx = IDLE;
      endcase
      cs_n_nx       = (state_nx == IDLE) || (state_nx == GAP);
      in_ready_nx   = (state_nx == IDLE) || (state_nx == WAIT);
      frame_done_nx = (state == HOLD) && (state_nx != HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_n       <= 1'b1;
         busy       <= 1'b0;
         in_ready   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         cs_n       <= cs_n_nx;
         busy       <= ~cs_n_nx;
         in_ready   <= in_ready_nx;
         frame_done <= frame_done_nx;
      end
   end

   // Zero-fill on shift leaves mosi low once a word has fully drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg     <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
      end else if (accept) begin
         sreg    <= in_data;
         bit_cnt <= '0;
         if (state == IDLE) word_cnt <= '0;
      end else if (trail_strb) begin
         sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
         if (last_bit) begin
            bit_cnt  <= '0;
            word_cnt <= last_word ? '0 : word_cnt + 1'b1;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
`ifdef TEAM_06_SPI_TX_CS_GAP_EN
      else if ((state == GAP) && sg_tc) begin
         bit_cnt <= gap_done ? '0 : bit_cnt + 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_team_06_spi_stream_tx.sv
// Bench for team_06_spi_stream_tx: accepted words go into a scoreboard
// queue; an SPI-side monitor rebuilds words from leading-edge samples
// and checks framing/timing rules against the scoreboard.
module tb_team_06_spi_stream_tx;

   localparam int   DATA_W  = 8;
   localparam int   CLK_DIV = 4;
   localparam int   WPF     = 2;
   localparam logic CPOL    = 1'b0;
`ifdef TEAM_06_SPI_TX_CS_GAP_EN
   localparam int GAP_CYC = 2 * CLK_DIV;
`else
   localparam int GAP_CYC = 0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready, sclk, cs_n, mosi, busy, frame_done;

   team_06_spi_stream_tx #(
      .DATA_W          (DATA_W),
      .CLK_DIV         (CLK_DIV),
      .WORDS_PER_FRAME (WPF),
      .CPOL            (CPOL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sclk       (sclk),
      .cs_n       (cs_n),
      .mosi       (mosi),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endfunction

   typedef struct {
      logic [DATA_W-1:0] data;
      int                acc;
   } xfer_t;

   xfer_t exp_q[$];
   int    tot_acc = 0;

   // Scoreboard: every handshake becomes an expected SPI word.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         tot_acc = 0;
      end else if (in_valid && in_ready) begin
         exp_q.push_back(xfer_t'{in_data, cyc});
         tot_acc++;
      end
   end

   // Monitor
   logic              prev_cs_n, prev_sclk;
   logic [DATA_W-1:0] rx;
   xfer_t             got;
   int                bits, trails, words_in_frame, tot_done, fd_cnt;
   int                last_edge, last_trail, since_rise;
   bit                armed;

   always @(negedge clk or posedge rst) begin
      if (rst) begin
         armed = 0; prev_cs_n = 1'b1; prev_sclk = CPOL; rx = '0;
         bits = 0; trails = 0; words_in_frame = 0; tot_done = 0; fd_cnt = 0;
         last_edge = 0; last_trail = 0; since_rise = 1000;
      end else if (!armed) begin
         armed = 1; prev_cs_n = cs_n; prev_sclk = sclk;
      end else begin
         if (prev_cs_n && !cs_n) begin
            chk("cs_high_len", since_rise >= GAP_CYC, 1);
            words_in_frame = 0;
            chk("fall_has_word", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("cs_fall_cycle", cyc - exp_q[0].acc, 1);
         end
         if (sclk != prev_sclk) begin
            if (sclk != CPOL) begin
               chk("lead_has_word", (exp_q.size() > 0) && (bits < DATA_W), 1);
               if (bits == 0) begin
                  if (exp_q.size() > 0) chk("first_lead_cycle", cyc - exp_q[0].acc, 1 + CLK_DIV);
               end else begin
                  chk("edge_spacing", cyc - last_edge, CLK_DIV);
               end
               rx = {rx[DATA_W-2:0], mosi};
               bits++;
               if (bits == DATA_W && exp_q.size() > 0) begin
                  got = exp_q.pop_front();
                  chk("word_data", rx, got.data);
               end
            end else begin
               chk("trail_after_lead", trails < bits, 1);
               chk("edge_spacing", cyc - last_edge, CLK_DIV);
               trails++;
               if (trails == DATA_W) begin
                  trails = 0; bits = 0; tot_done++; words_in_frame++; last_trail = cyc;
               end
            end
            last_edge = cyc;
         end
         if (!prev_cs_n && cs_n) begin
            chk("words_per_frame", words_in_frame, WPF);
            chk("hold_len", cyc - last_trail, CLK_DIV);
            since_rise = 0;
         end else if (cs_n) begin
            since_rise++;
         end
         if (frame_done) fd_cnt++;
         chk("frame_done", frame_done, !prev_cs_n && cs_n);
         chk("busy", busy, !cs_n);
         if (cs_n) begin
            chk("idle_sclk", sclk, CPOL);
            chk("idle_mosi", mosi, 0);
            chk("idle_ready", in_ready, since_rise >= GAP_CYC);
         end else begin
            chk("frame_ready", in_ready, (tot_acc == tot_done) && (words_in_frame < WPF));
            if (tot_acc == tot_done) chk("park_sclk", sclk, CPOL);
         end
         prev_cs_n = cs_n;
         prev_sclk = sclk;
      end
   end

   int sent = 0;

   task automatic send(input logic [DATA_W-1:0] d);
      int  n  = 0;
      bit  ok = 0;
      in_valid = 1'b1;
      while (!ok && n <= 2000) begin
         @(negedge clk);
         if (in_ready) begin
            in_data = d;
            ok = 1;
         end else begin
            in_data = DATA_W'($urandom);
            n++;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: got no in_ready within %0d cycles expected in_ready=1", n);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_data  = DATA_W'($urandom);
         sent++;
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         in_data = DATA_W'($urandom);
      end
   endtask

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: got no end of test expected finish before time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sclk", sclk, CPOL);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_mosi", mosi, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      rst = 1'b0;

      // back-to-back words in one frame
      send(8'h3C);
      send(8'hF0);
      // upstream stall between words of a frame
      send(8'hA7);
      idle(10);
      send(8'h81);

      // abort mid-frame
      send(8'h55);
      repeat (19) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_cs_n", cs_n, 1);
      chk("abort_sclk", sclk, CPOL);
      chk("abort_mosi", mosi, 0);
      chk("abort_busy", busy, 0);
      chk("abort_frame_done", frame_done, 0);
      chk("abort_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      sent = 0;

      send(8'hC3);
      send(8'h5A);

      for (int f = 0; f < 25; f++) begin
         for (int k = 0; k < WPF; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
            send(DATA_W'($urandom));
         end
      end

      w = 0;
      while ((busy || exp_q.size() != 0) && w < 1000) begin
         @(posedge clk);
         w++;
      end
      repeat (GAP_CYC + 4) @(posedge clk);
      #1;
      chk("drain_in_time", w < 1000, 1);
      chk("drain_queue", exp_q.size(), 0);
      chk("words_done", tot_done, tot_acc);
      chk("frame_done_count", fd_cnt, sent / WPF);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
